nibble_serial_adder: RTL and testbench
======================================

# nibble_serial_adder

Multi-cycle WIDTH-bit adder that reuses a single `full_adder_4bit` instance over WIDTH/4 clock cycles, least-significant nibble first. It sits directly around the 4-bit adder in the datapath. It registers wide operands, feeds the adder one nibble per cycle with the carry registered between cycles, and collects the sum nibbles into a full-width result. A valid/ready handshake is provided on both the operand side and the result side.

## Interface
- `WIDTH`, default 16: operand/result width. Must be a multiple of 4 and ≥ 8. NIBBLES = WIDTH/4.
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `in_valid`  input  1  operand request.
- `in_ready`  output  1  high only in IDLE.
- `a`  input  WIDTH  operand A, sampled on accept.
- `b`  input  WIDTH  operand B, sampled on accept.
- `cin`  input  1  carry-in, sampled on accept.
- `sub`  input  1  subtract select; present only with `NIBBLE_ADDER_SUB_EN`.
- `out_valid`  output  1  result available.
- `out_ready`  input  1  result consumer ready.
- `sum`  output  WIDTH  result, registered.
- `cout`  output  1  carry-out of the MSB nibble, registered.
- `busy`  output  1  high in RUN or DONE.

## Operation
- Internal state: `a_sh`, `b_sh` (WIDTH, right-shifting), `carry` (1 bit), `acc` (WIDTH), and a nibble counter of width clog2(NIBBLES).
- FSM has three states: IDLE, RUN and DONE.
- **IDLE:** `in_ready`=1. Accept occurs on an edge where `in_valid & in_ready`:
  - `a_sh`←a, `b_sh`←b, `carry`←cin, counter←0.
  - Next state is RUN.
- **RUN:** each cycle drives the adder with a_sh[3:0], b_sh[3:0] and `carry`. On the edge:
  - `acc`←{adder sum, acc[WIDTH-1:4]}, so nibbles enter at the top and shift down.
  - `carry`←adder cout.
  - `a_sh` and `b_sh` shift right by 4.
  - Counter increments.
  - On the edge where counter==NIBBLES-1, the FSM goes to DONE.
- **DONE:** `out_valid`=1, and `sum`=`acc` and `cout`=`carry` are held stable.
  - On an edge with `out_valid & out_ready`, the FSM returns to IDLE.
  - `sum` and `cout` keep their last values in IDLE.
- Arithmetic is modulo 2^WIDTH. `cout` is the true carry out of bit WIDTH-1.
- `in_valid` is ignored while `busy`; operands presented then are neither captured nor queued.
- `a`, `b` and `cin` may change freely after the accept edge.

## Timing
- Reset (asynchronous assert, any state):
  - FSM→IDLE.
  - `sum`=0, `cout`=0, `out_valid`=0, `busy`=0, `in_ready`=1, and all internal registers 0.
  - An operation in progress is discarded; no partial result is ever presented.
- Latency: `out_valid` rises exactly NIBBLES cycles after the accept edge (4 cycles for WIDTH=16).
- Minimum initiation interval is NIBBLES+2 cycles:
  - 1 accept cycle,
  - NIBBLES RUN cycles,
  - ≥1 DONE cycle.
- `in_ready` returns high in the cycle after the result handshake edge. There are no back-to-back accepts.
- Backpressure: while `out_ready`=0 in DONE, `out_valid`, `sum` and `cout` must not change.
- `out_ready` held high before DONE has no effect. The result handshake completes on the first DONE edge.

## Configuration
- `NIBBLE_ADDER_SUB_EN` defined:
  - The `sub` port exists.
  - On accept with sub=1, `b_sh`←~b and `carry`←1, with `cin` ignored. The result is a−b mod 2^WIDTH.
  - `cout`=1 means no borrow (a ≥ b, unsigned).
  - With sub=0, behaviour is identical to the undefined case.
- `NIBBLE_ADDER_SUB_EN` undefined: no `sub` port; addition only.

## Test plan
- Basic add: a=0x1234, b=0x4321, cin=0 → after 4 cycles, sum=0x5555, cout=0, out_valid=1.
- Full ripple carry: a=0xFFFF, b=0x0001, cin=0 → sum=0x0000, cout=1.
- Carry-in across nibbles: a=0x0FFF, b=0x0000, cin=1 → sum=0x1000, cout=0.
- Backpressure and busy ignore:
  - Stimulus: out_ready=0 for 3 DONE cycles, with in_valid=1 and new operands toggling throughout.
  - Required response: sum/cout stay stable and in_ready=0 throughout; a single result handshake occurs on the first edge with out_ready=1; in_ready=1 on the next cycle.
- Reset mid-operation: rst_n low during the 2nd RUN cycle → outputs go to reset values immediately; after release, a fresh 0x0001+0x0001 returns 0x0002 with no stale data.
- With `NIBBLE_ADDER_SUB_EN`:
  - 0x0007−0x0005 → sum=0x0002, cout=1.
  - 0x0005−0x0007 → sum=0xFFFE, cout=0.

Source files
------------

// File: rtl/nibble_serial_adder.sv
// Purpose: WIDTH-bit add (or subtract with NIBBLE_ADDER_SUB_EN) on one shared 4-bit adder, LS nibble first.
// Latency: out_valid rises WIDTH/4 cycles after the accept edge; initiation interval is at least WIDTH/4+2 cycles.
// Backpressure: in DONE, sum/cout/out_valid hold until out_ready; in_valid is ignored while busy.

module full_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout
);
    assign {cout, s} = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
endmodule

module nibble_serial_adder #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef NIBBLE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);
    localparam int NIBBLES = WIDTH / 4;
    localparam int CW      = $clog2(NIBBLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh, acc;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [3:0]       fa_s;
    logic             fa_co;
    logic             accept;
    logic             last;
    logic [WIDTH-1:0] b_load;
    logic             carry_load;
    logic [WIDTH-1:0] acc_nxt;

    full_adder_4bit u_fa (
        .a    (a_sh[3:0]),
        .b    (b_sh[3:0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_co)
    );

`ifdef NIBBLE_ADDER_SUB_EN
    // Subtraction is a + ~b + 1; cin is deliberately ignored in that mode.
    assign b_load     = sub ? ~b : b;
    assign carry_load = sub ? 1'b1 : cin;
`else
    assign b_load     = b;
    assign carry_load = cin;
`endif

    assign in_ready  = (state == IDLE);
    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last      = (cnt == CW'(NIBBLES - 1));
    assign acc_nxt   = {fa_s, acc[WIDTH-1:4]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // sum/cout are loaded only on the final RUN edge so they never show partial results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh  <= '0;
            b_sh  <= '0;
            acc   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            cnt   <= '0;
        end else if (state == RUN) begin
            acc   <= acc_nxt;
            carry <= fa_co;
            a_sh  <= a_sh >> 4;
            b_sh  <= b_sh >> 4;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= acc_nxt;
                cout <= fa_co;
            end
        end
    end
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against an arithmetic reference model.
module tb_nibble_serial_adder;
    localparam int W = 16;
    localparam int N = W / 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         cin;
    logic         sub_sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
`ifdef NIBBLE_ADDER_SUB_EN
        .sub       (sub_sel),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {cout, sum} straight from the arithmetic definition.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci, input logic sb);
        longint       s;
        logic [W-1:0] d;
        logic [W:0]   r;
        if (sb) begin
            d = x - y;
            r = {(x >= y), d};
        end else begin
            s = longint'(x) + longint'(y) + longint'(ci);
            r = s[W:0];
        end
        return r;
    endfunction

    // Entered and left at a falling edge with the DUT idle.
    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                          input logic sb, input int hold, input bit noise);
        logic [W:0] exp;
        exp = ref_op(x, y, ci, sb);
        chk("in_ready_idle", in_ready, 1'b1);
        a = x; b = y; cin = ci; sub_sel = sb; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        for (int k = 1; k <= N; k++) begin
            in_valid  = noise;
            a         = W'($urandom);
            b         = W'($urandom);
            cin       = 1'($urandom);
            sub_sel   = 1'($urandom);
            out_ready = (hold == 0) ? 1'b1 : 1'($urandom);
            if (k == N && hold != 0) out_ready = 1'b0;
            @(posedge clk); @(negedge clk);
            chk("out_valid_latency", out_valid, (k == N));
            chk("busy_run", busy, 1'b1);
            chk("in_ready_busy", in_ready, 1'b0);
        end
        chk("sum", sum, exp[W-1:0]);
        chk("cout", cout, exp[W]);
        for (int h = 0; h < hold; h++) begin
            out_ready = (h == hold - 1) ? 1'b1 : 1'b0;
            if (h != hold - 1) begin
                in_valid = noise;
                a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            end
            if (h == hold - 1) break;
            @(posedge clk); @(negedge clk);
            chk("bp_out_valid", out_valid, 1'b1);
            chk("bp_sum", sum, exp[W-1:0]);
            chk("bp_cout", cout, exp[W]);
            chk("bp_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("hs_out_valid", out_valid, 1'b0);
        chk("hs_in_ready", in_ready, 1'b1);
        chk("hs_busy", busy, 1'b0);
        chk("idle_sum_hold", sum, exp[W-1:0]);
        chk("idle_cout_hold", cout, exp[W]);
        in_valid  = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        logic sb;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub_sel = 1'b0;
        @(negedge clk);
        chk("rst_sum", sum, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b1);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
        run_op(16'h0FFF, 16'h0000, 1'b1, 1'b0, 0, 1'b0);
        run_op(16'hA5A5, 16'h1111, 1'b1, 1'b0, 4, 1'b1);

        // Reset asserted during the second RUN cycle.
        a = 16'h7777; b = 16'h8888; cin = 1'b1; in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_sum", sum, '0);
        chk("mid_rst_cout", cout, 1'b0);
        chk("mid_rst_out_valid", out_valid, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_in_ready", in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(16'h0001, 16'h0001, 1'b0, 1'b0, 0, 1'b0);

`ifdef NIBBLE_ADDER_SUB_EN
        run_op(16'h0007, 16'h0005, 1'b1, 1'b1, 0, 1'b0);
        run_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1, 1'b1);
`endif

        for (int i = 0; i < 24; i++) begin
`ifdef NIBBLE_ADDER_SUB_EN
            sb = 1'($urandom);
`else
            sb = 1'b0;
`endif
            run_op(W'($urandom), W'($urandom), 1'($urandom), sb,
                   int'($urandom_range(0, 3)), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
